// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// The RF_WB_BYPASS_EN build option is handled in rf_wb_arbiter.sv.
package rf_wb_arbiter_pkg;

    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NUM_REGS);
    localparam int unsigned WB_DATA_W  = 32;

    // One write-back request; also the layout of the registered output stage.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back request channel: valid/ready handshake carrying a destination register and data.
interface rf_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    import rf_wb_arbiter_pkg::*;

    logic                  valid;
    logic                  ready;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-input round-robin grant generator; owns the priority pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       hold,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio_q, prio_d;

    // Grants depend only on valid, prio and hold so ready never loops through the requester.
    always_comb begin
        grant = 2'b00;
        if (!hold) begin
            if (valid == 2'b11) grant = prio_q ? 2'b10 : 2'b01;
            else                grant = valid;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (grant[0])      prio_d = 1'b1;
        else if (grant[1]) prio_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prio_q <= 1'b0;
        else          prio_q <= prio_d;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the integer register file: round-robin between two requesters,
// one-deep registered write stage and read-after-write hit reporting (forwarding with RF_WB_BYPASS_EN).
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  hold,
    rf_wb_arbiter_if.slave        req0,
    rf_wb_arbiter_if.slave        req1,
    output logic                  rf_write,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
`ifdef RF_WB_BYPASS_EN
    output logic [DATA_W-1:0]     rs1_fwd,
    output logic [DATA_W-1:0]     rs2_fwd,
`endif
    output logic                  rs1_hit,
    output logic                  rs2_hit
);

    logic [1:0] grant;
    wb_req_t    out_q, out_d;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (hold),
        .valid   ({req1.valid, req0.valid}),
        .grant   (grant)
    );

    assign req0.ready = grant[0];
    assign req1.ready = grant[1];

    // Writes to x0 still handshake but load a non-valid stage so x0 is never written or hit.
    always_comb begin
        out_d       = out_q;
        out_d.valid = 1'b0;
        if (grant[0]) begin
            out_d.valid = (req0.addr != '0);
            out_d.addr  = req0.addr;
            out_d.data  = req0.data;
        end else if (grant[1]) begin
            out_d.valid = (req1.addr != '0);
            out_d.addr  = req1.addr;
            out_d.data  = req1.data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_q <= '0;
        else          out_q <= out_d;
    end

    assign rf_write = out_q.valid;
    assign rf_waddr = out_q.addr;
    assign rf_wdata = out_q.data;

    assign rs1_hit = out_q.valid && (out_q.addr == rs1_addr) && (rs1_addr != '0);
    assign rs2_hit = out_q.valid && (out_q.addr == rs2_addr) && (rs2_addr != '0);

`ifdef RF_WB_BYPASS_EN
    assign rs1_fwd = rs1_hit ? out_q.data : '0;
    assign rs2_fwd = rs2_hit ? out_q.data : '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: stimulus pushes expectations, a negedge monitor checks them.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          hold = 1'b0;
    logic [4:0]    rs1_addr = '0;
    logic [4:0]    rs2_addr = '0;
    logic          rf_write;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rs1_hit, rs2_hit;
`ifdef RF_WB_BYPASS_EN
    logic [DW-1:0] rs1_fwd, rs2_fwd;
`endif

    rf_wb_arbiter_if #(.DATA_W(DW)) req0_if ();
    rf_wb_arbiter_if #(.DATA_W(DW)) req1_if ();

    rf_wb_arbiter #(.DATA_W(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hold     (hold),
        .req0     (req0_if),
        .req1     (req1_if),
        .rf_write (rf_write),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
`ifdef RF_WB_BYPASS_EN
        .rs1_fwd  (rs1_fwd),
        .rs2_fwd  (rs2_fwd),
`endif
        .rs1_hit  (rs1_hit),
        .rs2_hit  (rs2_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        write;
        bit [4:0]  addr;
        bit [31:0] data;
    } rf_exp_t;

    typedef struct {
        bit        r0, r1, h1, h2;
        bit [31:0] f1, f2;
    } cyc_exp_t;

    rf_exp_t  rf_q[$];
    cyc_exp_t cyc_q[$];
    int       n_checks = 0;
    int       n_fail = 0;
    bit       in_reset = 1'b1;

    // Reference model: preferred requester and the write the register file sees this cycle.
    int       pref = 0;
    rf_exp_t  cur;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        pref = 0;
        cur = '{write: 1'b0, addr: 5'd0, data: 32'd0};
        rf_q.delete();
        cyc_q.delete();
        rf_q.push_back(cur);
    endtask

    task automatic set_idle();
        req0_if.valid = 1'b0; req0_if.addr = '0; req0_if.data = '0;
        req1_if.valid = 1'b0; req1_if.addr = '0; req1_if.data = '0;
        hold = 1'b0; rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic drive(input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                         input bit v1, input bit [4:0] a1, input bit [31:0] d1,
                         input bit h, input bit [4:0] r1, input bit [4:0] r2);
        int       g;
        cyc_exp_t ce;
        rf_exp_t  nx;
        @(posedge clk);
        #1;
        req0_if.valid = v0; req0_if.addr = a0; req0_if.data = d0;
        req1_if.valid = v1; req1_if.addr = a1; req1_if.data = d1;
        hold = h; rs1_addr = r1; rs2_addr = r2;
        g = -1;
        if (!h) begin
            if (v0 && v1) g = pref;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        ce.r0 = (g == 0);
        ce.r1 = (g == 1);
        ce.h1 = cur.write && (cur.addr == r1) && (r1 != 0);
        ce.h2 = cur.write && (cur.addr == r2) && (r2 != 0);
        ce.f1 = ce.h1 ? cur.data : 32'd0;
        ce.f2 = ce.h2 ? cur.data : 32'd0;
        cyc_q.push_back(ce);
        nx = '{write: 1'b0, addr: cur.addr, data: cur.data};
        if (g == 0) begin
            nx = '{write: (a0 != 0), addr: a0, data: d0};
            pref = 1;
        end else if (g == 1) begin
            nx = '{write: (a1 != 0), addr: a1, data: d1};
            pref = 0;
        end
        rf_q.push_back(nx);
        cur = nx;
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 7) == 0,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endtask

    initial begin : monitor
        cyc_exp_t c;
        rf_exp_t  r;
        forever begin
            @(negedge clk);
            if (!in_reset && cyc_q.size() > 0 && rf_q.size() > 0) begin
                c = cyc_q.pop_front();
                r = rf_q.pop_front();
                check("req0_ready", 64'(req0_if.ready), 64'(c.r0));
                check("req1_ready", 64'(req1_if.ready), 64'(c.r1));
                check("rf_write", 64'(rf_write), 64'(r.write));
                if (r.write) begin
                    check("rf_waddr", 64'(rf_waddr), 64'(r.addr));
                    check("rf_wdata", 64'(rf_wdata), 64'(r.data));
                end
                check("rs1_hit", 64'(rs1_hit), 64'(c.h1));
                check("rs2_hit", 64'(rs2_hit), 64'(c.h2));
`ifdef RF_WB_BYPASS_EN
                check("rs1_fwd", 64'(rs1_fwd), 64'(c.f1));
                check("rs2_fwd", 64'(rs2_fwd), 64'(c.f2));
`endif
            end
        end
    end

    initial begin : stimulus
        set_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rf_write", 64'(rf_write), 64'd0);
        check("reset_rf_waddr", 64'(rf_waddr), 64'd0);
        check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        reset_n = 1'b1;
        model_reset();
        in_reset = 1'b0;

        drive(1, 5'd1, 32'h11, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
        drive(0, 5'd0, 32'd0, 1, 5'd2, 32'h22, 0, 5'd1, 5'd0);
        repeat (4) drive(1, 5'd5, 32'hAAAA0000, 1, 5'd6, 32'h12345678, 0, 5'd5, 5'd6);
        drive(0, 5'd0, 32'd0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd6);
        drive(1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 0, 5'd0, 5'd0);
        drive(1, 5'd3, 32'h33, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
        drive(1, 5'd4, 32'h44, 1, 5'd8, 32'h88, 1, 5'd3, 5'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd3, 5'd0);
        drive(1, 5'd7, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd7, 5'd0);
        drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd7, 5'd7);

        repeat (300) drive_random();

        // Asynchronous reset while a write is pending: it must vanish without committing.
        drive(1, 5'd9, 32'hCAFEF00D, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        set_idle();
        check("pre_reset_write", 64'(rf_write), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_reset_write", 64'(rf_write), 64'd0);
        check("async_reset_waddr", 64'(rf_waddr), 64'd0);
        check("async_reset_wdata", 64'(rf_wdata), 64'd0);
        @(posedge clk);
        #1;
        check("no_commit_after_reset", 64'(rf_write), 64'd0);
        reset_n = 1'b1;
        model_reset();
        in_reset = 1'b0;

        drive(0, 5'd0, 32'd0, 1, 5'd10, 32'hA5A5A5A5, 0, 5'd0, 5'd0);
        drive(1, 5'd11, 32'h5A5A5A5A, 1, 5'd12, 32'h0F0F0F0F, 0, 5'd10, 5'd0);
        repeat (60) drive_random();

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(cyc_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
